// File: rtl/cr_osf_ia_ctl.sv
// cr_osf_ia_ctl: indirect-access command engine sharing one memory port with a datapath
// Ports: cfg_* / ia_wdata accept a NOP/READ/WRITE/CLEAR command; ia_rdata/ia_busy/ia_code/ia_overrun report it;
//        dp_* is the datapath requester (priority, dp_gnt grant); mem_* is the shared port, mem_rdata one cycle after a read.
module cr_osf_ia_ctl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 96,
    parameter int DEPTH      = 512,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr_stb,
    input  logic [3:0]        cfg_op,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] ia_wdata,
    output logic [DATA_W-1:0] ia_rdata,
    output logic              ia_busy,
    output logic [1:0]        ia_code,
    output logic              ia_overrun,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_gnt,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RD_WAIT = 2'd2, S_CLEAR = 2'd3;
    localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] W_SMAX = SW'(STARVE_MAX);
    localparam logic [ADDR_W:0] W_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(DEPTH - 1);
    logic [1:0]        r_state;
    logic              r_we, r_act, r_ovr;
    logic [1:0]        r_code;
    logic [ADDR_W-1:0] r_addr, r_idx;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [SW-1:0]     r_starve;
    logic              w_rw, w_err_op, w_err_addr, w_accept, w_pend, w_ia_win, w_clr;
    assign w_rw       = cfg_op == 4'd1 || cfg_op == 4'd2;
    assign w_err_op   = cfg_op > 4'd3;
    assign w_err_addr = w_rw && {1'b0, cfg_addr} >= W_DEPTH;
    assign w_accept   = cfg_wr_stb && r_state == S_IDLE;
    assign w_clr      = r_state == S_CLEAR;
    // r_act is low for NOP/error commands: they spend one busy cycle in ACCESS without requesting
    assign w_pend     = (r_state == S_ACCESS && r_act) || w_clr;
    assign w_ia_win   = w_pend && (!dp_req || r_starve == W_SMAX);
    assign dp_gnt     = rst_n && dp_req && !w_ia_win;
    assign mem_ce     = w_ia_win || dp_gnt;
    assign mem_we     = w_ia_win ? (w_clr || r_we) : dp_gnt && dp_we;
    assign mem_addr   = w_ia_win ? (w_clr ? r_idx : r_addr) : dp_gnt ? dp_addr : '0;
    assign mem_wdata  = w_ia_win ? (w_clr ? '0 : r_wdata) : dp_gnt ? dp_wdata : '0;
    assign ia_busy    = r_state != S_IDLE;
    assign ia_code    = r_code;
    assign ia_overrun = r_ovr;
    assign ia_rdata   = r_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_act    <= 1'b0;
            r_ovr    <= 1'b0;
            r_code   <= 2'd0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_starve <= '0;
        end else begin
            r_starve <= (!w_pend || w_ia_win) ? '0 : r_starve + 1'b1;
            // a strobe while busy sets overrun; an accepted strobe clears it
            if (cfg_wr_stb)
                r_ovr <= r_state != S_IDLE;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we    <= cfg_op == 4'd2;
                    r_addr  <= cfg_addr;
                    r_wdata <= ia_wdata;
                    r_act   <= w_rw && !w_err_addr;
                    r_code  <= w_err_op ? 2'd1 : w_err_addr ? 2'd2 : 2'd0;
                    r_idx   <= '0;
                    r_state <= cfg_op == 4'd3 ? S_CLEAR : S_ACCESS;
                end
                S_ACCESS: r_state <= !r_act ? S_IDLE : !w_ia_win ? S_ACCESS : r_we ? S_IDLE : S_RD_WAIT;
                S_RD_WAIT: begin
                    r_rdata <= mem_rdata;
                    r_state <= S_IDLE;
                end
                default: if (w_ia_win) begin
                    r_idx   <= r_idx == W_LAST ? '0 : r_idx + 1'b1;
                    r_state <= r_idx == W_LAST ? S_IDLE : S_CLEAR;
                end
            endcase
        end
    end
endmodule
